md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_calc.sv | 56 +++++
 rtl/md_ctrl.sv | 133 +++++++++++++
 tb/tb_md_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op codes, operation latencies and FSM state encoding used by md_ctrl and md_calc.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath.
// Ports:
//   op   - latched operation code
//   a, b - latched operands (rs, rt)
//   res  - 64-bit result, {HI, LO}
//   div0 - divide op with a zero divisor; result must not be written
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div0
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic        [63:0] ua64;
  logic        [63:0] ub64;
  logic        [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] bsafe;
  logic        [31:0] squot;
  logic        [31:0] srem;
  logic        [31:0] uquot;
  logic        [31:0] urem;

  assign sa64  = {{32{a[31]}}, a};
  assign sb64  = {{32{b[31]}}, b};
  assign ua64  = {32'd0, a};
  assign ub64  = {32'd0, b};
  assign sprod = sa64 * sb64;
  assign uprod = ua64 * ub64;

  // Divisor forced non-zero so the dividers never see 0; result is discarded via div0 anyway.
  assign bsafe = (b == 32'd0) ? 32'd1 : b;
  assign squot = $signed(a) / $signed(bsafe);
  assign srem  = $signed(a) % $signed(bsafe);
  assign uquot = a / bsafe;
  assign urem  = a % bsafe;

  assign div0 = is_div(op) && (b == 32'd0);

  always_comb begin
    res = 64'd0;
    case (op)
      MD_MULT:  res = sprod;
      MD_MULTU: res = uprod;
      MD_DIV:   res = {srem, squot};
      MD_DIVU:  res = {urem, uquot};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide unit controller: FSM, latency counter, HI/LO registers and pipeline stall.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   start, op       - E-stage mult/div/mthi/mtlo request and its op code
//   cancel          - kill the E-stage request (only effective in IDLE)
//   a, b            - rs/rt operand values
//   d_is_md         - D-stage instruction touches HI/LO or is a mult/div
//   busy            - operation in flight
//   stall           - freeze PC and D register
//   hi, lo          - architectural HI/LO
// Optional feature: define MDU_DIV0_FAST_EN to finish divide-by-zero after one busy cycle.
module md_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        long_op;
  logic [3:0]  cnt_load;
  logic [63:0] res;
  logic        div0;

  md_calc u_calc (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .res  (res),
    .div0 (div0)
  );

  assign accept  = (state_q == StIdle) && start && !cancel;
  assign long_op = (op <= MD_DIVU);

  always_comb begin
    if ((op == MD_MULT) || (op == MD_MULTU)) begin
      cnt_load = 4'(MULT_LAT - 1);
    end else begin
      cnt_load = 4'(DIV_LAT - 1);
    end
`ifdef MDU_DIV0_FAST_EN
    if (is_div(op) && (b == 32'd0)) begin
      cnt_load = 4'd0;
    end
`else
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (long_op) begin
            state_d = StRun;
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = cnt_load;
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        // start and cancel are deliberately ignored here: accepted ops always complete.
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          if (!div0) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign stall = d_is_md && (busy || (accept && long_op));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

`ifdef MDU_DIV0_FAST_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = 10;
`endif

  md_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .cancel  (cancel),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
  endtask

  // Called in the start cycle; checks busy high for n cycles, then low.
  task automatic busy_for(input string tag, input int n);
    tick();
    start = 1'b0;
    a     = 32'hA5A5_5A5A;
    b     = 32'h0F0F_F0F0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    #1;
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 3'd0;
    cancel  = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    d_is_md = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // mult -2 * 3, operands scrambled during RUN
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    busy_for("mult", 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // divu 7/2, with an illegal mthi attempt during RUN that must be ignored
    issue(3'd3, 32'd7, 32'd2);
    tick();
    start = 1'b0;
    tick();
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    chk("divu_busy_last", {31'd0, busy}, 32'd1);
    tick();
    chk("divu_done", {31'd0, busy}, 32'd0);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    // div -7/2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    busy_for("div", 10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    // mthi: no busy cycle
    issue(3'd4, 32'h0000_1234, 32'd0);
    tick();
    start = 1'b0;
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'hFFFF_FFFD);

    // div by zero leaves HI/LO alone
    issue(3'd2, 32'd5, 32'd0);
    busy_for("div0", Div0Lat);
    chk("div0_hi", hi, 32'h0000_1234);
    chk("div0_lo", lo, 32'hFFFF_FFFD);

    // cancel in the start cycle discards the op
    issue(3'd0, 32'd2, 32'd3);
    cancel = 1'b1;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("cancel_busy_late", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'h0000_1234);
    chk("cancel_lo", lo, 32'hFFFF_FFFD);

    // stall: multu with d_is_md held high
    d_is_md = 1'b1;
    #1;
    chk("stall_idle", {31'd0, stall}, 32'd0);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    #1;
    chk("stall_start", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_busy", {31'd0, stall}, 32'd1);
      tick();
    end
    #1;
    chk("stall_clear", {31'd0, stall}, 32'd0);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    d_is_md = 1'b0;

    // reset in cycle 4 of a div aborts it
    issue(3'd2, 32'd100, 32'd7);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    chk("abort_late_hi", hi, 32'd0);
    chk("abort_late_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
